// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: sequencer states, fault codes and
// the major opcode list (instr[6:2]) used by both the sequencer's legality
// check and the instruction-control decoder.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] FAULT_NONE          = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL       = 2'd1;
  localparam logic [1:0] FAULT_FETCH_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_DATA_TIMEOUT  = 2'd3;

  // RV32I major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'h00;
  localparam logic [4:0] OPC_MISC_MEM = 5'h03;
  localparam logic [4:0] OPC_OP_IMM   = 5'h04;
  localparam logic [4:0] OPC_AUIPC    = 5'h05;
  localparam logic [4:0] OPC_STORE    = 5'h08;
  localparam logic [4:0] OPC_OP       = 5'h0c;
  localparam logic [4:0] OPC_LUI      = 5'h0d;
  localparam logic [4:0] OPC_BRANCH   = 5'h18;
  localparam logic [4:0] OPC_JALR     = 5'h19;
  localparam logic [4:0] OPC_JAL      = 5'h1b;

  // addi x0,x0,0 -- what the instruction register holds out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True for every major opcode the core implements.
  function automatic logic is_legal_opcode(input logic [4:0] opc);
    logic legal;
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer
// (master) and the memory ports (slave).
//
// Handshake: a request line (instr_mem_req, data_mem_read_req,
// data_mem_write_req) is raised by the master and held, unchanged, until the
// slave answers with the matching ready (instr_mem_ready / data_mem_ready)
// in the same cycle. The transfer completes in the cycle where request and
// ready are both high; instr_mem_data is only meaningful in that cycle. The
// request drops in the following cycle. Ready seen without a request is
// ignored.
interface core_sequencer_if;
  logic        instr_mem_req;
  logic        instr_mem_ready;
  logic [31:0] instr_mem_data;
  logic        data_mem_read_req;
  logic        data_mem_write_req;
  logic        data_mem_ready;

  modport master (
    output instr_mem_req,
    output data_mem_read_req,
    output data_mem_write_req,
    input  instr_mem_ready,
    input  instr_mem_data,
    input  data_mem_ready
  );

  modport slave (
    input  instr_mem_req,
    input  data_mem_read_req,
    input  data_mem_write_req,
    output instr_mem_ready,
    output instr_mem_data,
    output data_mem_ready
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory ready. expired is raised in the
// waiting cycle that would bring the count up to limit, so the caller can
// still prefer a ready arriving in that same cycle.
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  // wait counter: cleared on reset or state entry, advances while waiting
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign expired = tick && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core. Steps each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB, handshakes
// with the memory ports and turns the decoder's level signals into one-cycle
// enables.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  core_sequencer_if.master   mem,
  output logic [31:0]        instr,
  input  logic               should_read_mem,
  input  logic               should_write_mem,
  input  logic               should_write_reg,
  output logic               reg_write_en,
  output logic               pc_write_en,
  output logic [31:0]        retire_count,
  output logic               fault,
  output logic [1:0]         fault_code,
  output state_t             dbg_state
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [1:0] fault_code_next;
  logic       load_instr;
  logic       retire;
  logic       wait_clear;
  logic       wait_tick;
  logic       wait_expired;
  logic       instr_legal;

  // A load that is also a store is treated like a bad opcode.
  assign instr_legal = (instr[1:0] == 2'b11) && is_legal_opcode(instr[6:2]) &&
                       !(should_read_mem && should_write_mem);

  // The wait counter restarts whenever the FSM enters a new state, which
  // covers entry into both FETCH and MEM.
  assign wait_clear = (state_next != state);

  mem_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (reset),
    .clear   (wait_clear),
    .tick    (wait_tick),
    .limit   (TIMEOUT_LIMIT),
    .expired (wait_expired)
  );

  // state, instruction register, retire counter and fault code
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      instr        <= NOP_INSTR;
      retire_count <= 32'd0;
      fault_code   <= FAULT_NONE;
    end else begin
      state      <= state_next;
      fault_code <= fault_code_next;
      if (load_instr) begin
        instr <= mem.instr_mem_data;
      end
      if (retire) begin
        retire_count <= retire_count + 32'd1;
      end
    end
  end

  // next-state and per-state request/strobe decode
  always_comb begin
    state_next             = state;
    fault_code_next        = fault_code;
    load_instr             = 1'b0;
    retire                 = 1'b0;
    wait_tick              = 1'b0;
    mem.instr_mem_req      = 1'b0;
    mem.data_mem_read_req  = 1'b0;
    mem.data_mem_write_req = 1'b0;
    reg_write_en           = 1'b0;
    pc_write_en            = 1'b0;
    case (state)
      FETCH: begin
        mem.instr_mem_req = 1'b1;
        if (mem.instr_mem_ready) begin
          load_instr = 1'b1;
          state_next = DECODE;
        end else begin
          wait_tick = 1'b1;
          if (wait_expired) begin
            state_next      = FAULT;
            fault_code_next = FAULT_FETCH_TIMEOUT;
          end
        end
      end
      DECODE: begin
        if (instr_legal) begin
          state_next = EXEC;
        end else begin
          state_next      = FAULT;
          fault_code_next = FAULT_ILLEGAL;
        end
      end
      EXEC: begin
        state_next = (should_read_mem || should_write_mem) ? MEM : WB;
      end
      MEM: begin
        mem.data_mem_read_req  = should_read_mem;
        mem.data_mem_write_req = should_write_mem;
        if (mem.data_mem_ready) begin
          state_next = WB;
        end else begin
          wait_tick = 1'b1;
          if (wait_expired) begin
            state_next      = FAULT;
            fault_code_next = FAULT_DATA_TIMEOUT;
          end
        end
      end
      WB: begin
        reg_write_en = should_write_reg;
        pc_write_en  = 1'b1;
        retire       = 1'b1;
        state_next   = FETCH;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign fault     = (state == FAULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios from the test
// plan plus randomized instruction streams checked against a per-instruction
// timing/strobe model.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int T = 4;  // MEM_TIMEOUT used for the DUT

  typedef struct {
    int         cycles;
    int         rd_cyc;
    int         wr_cyc;
    int         regw;
    int         regw_at;
    int         pcw;
    logic       faulted;
    logic [1:0] code;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr;
  logic        should_read_mem = 1'b0;
  logic        should_write_mem = 1'b0;
  logic        should_write_reg = 1'b0;
  logic        reg_write_en;
  logic        pc_write_en;
  logic [31:0] retire_count;
  logic        fault;
  logic [1:0]  fault_code;
  state_t      dbg_state;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_retire = 32'd0;
  logic [4:0]  legal_ops [10] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08,
                                  5'h0c, 5'h0d, 5'h18, 5'h19, 5'h1b};

  core_sequencer_if mem_bus ();

  core_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem              (mem_bus),
    .instr            (instr),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .should_write_reg (should_write_reg),
    .reg_write_en     (reg_write_en),
    .pc_write_en      (pc_write_en),
    .retire_count     (retire_count),
    .fault            (fault),
    .fault_code       (fault_code),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_bus.instr_mem_ready = 1'b0;
    mem_bus.data_mem_ready  = 1'b0;
    mem_bus.instr_mem_data  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_retire = 32'd0;
  endtask

  // decoder stand-in: level signals derived from the opcode field
  task automatic set_decoder(input logic [31:0] w);
    should_read_mem  = (w[6:2] == 5'h00);
    should_write_mem = (w[6:2] == 5'h08);
    should_write_reg = !(w[6:2] == 5'h08 || w[6:2] == 5'h18 || w[6:2] == 5'h03);
  endtask

  // Drives one instruction: fw not-ready fetch cycles, mw not-ready data
  // cycles, random ready noise when nothing is requested. Runs until the PC
  // strobe or a fault, observing from negedge to negedge.
  task automatic run_instr(input logic [31:0] word, input int fw, input int mw,
                           output obs_t o);
    int  cyc;
    int  f_cnt;
    int  m_cnt;
    bit  done;
    o = '{default: 0};
    cyc = 0; f_cnt = 0; m_cnt = 0; done = 0;
    while (!done && cyc < 100) begin
      cyc++;
      if (mem_bus.instr_mem_req) begin
        f_cnt++;
        mem_bus.instr_mem_ready = (f_cnt > fw);
        mem_bus.instr_mem_data  = (f_cnt > fw) ? word : $urandom();
      end else begin
        mem_bus.instr_mem_ready = 1'($urandom_range(0, 1));
        mem_bus.instr_mem_data  = $urandom();
      end
      if (mem_bus.data_mem_read_req)  o.rd_cyc++;
      if (mem_bus.data_mem_write_req) o.wr_cyc++;
      if (mem_bus.data_mem_read_req || mem_bus.data_mem_write_req) begin
        m_cnt++;
        mem_bus.data_mem_ready = (m_cnt > mw);
      end else begin
        mem_bus.data_mem_ready = 1'($urandom_range(0, 1));
      end
      if (reg_write_en) begin o.regw++; o.regw_at = cyc; end
      if (pc_write_en) begin o.pcw++; done = 1; end
      if (fault) begin o.faulted = 1'b1; done = 1; end
      @(negedge clk);
    end
    o.cycles = cyc;
    o.code   = fault_code;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL run_timeout: word %h no retire/fault within %0d cycles", word, cyc);
    end
    mem_bus.instr_mem_ready = 1'b0;
    mem_bus.data_mem_ready  = 1'b0;
  endtask

  // Reference: what one instruction should do given its memory wait profile.
  function automatic obs_t model_instr(input logic [31:0] w, input int fw, input int mw,
                                       input logic rd, input logic wr, input logic wreg);
    obs_t e;
    bit   legal;
    bit   op_ok;
    e = '{default: 0};
    op_ok = 0;
    foreach (legal_ops[i]) if (legal_ops[i] == w[6:2]) op_ok = 1;
    legal = (w[1:0] == 2'b11) && op_ok && !(rd && wr);
    if (fw >= T) begin
      e.faulted = 1; e.code = 2'd2; e.cycles = T + 1;
    end else if (!legal) begin
      e.faulted = 1; e.code = 2'd1; e.cycles = fw + 3;
    end else if ((rd || wr) && mw >= T) begin
      e.faulted = 1; e.code = 2'd3; e.cycles = fw + T + 4;
      e.rd_cyc = rd ? T : 0; e.wr_cyc = wr ? T : 0;
    end else begin
      e.cycles  = fw + 4 + ((rd || wr) ? mw + 1 : 0);
      e.rd_cyc  = rd ? mw + 1 : 0;
      e.wr_cyc  = wr ? mw + 1 : 0;
      e.regw    = wreg ? 1 : 0;
      e.regw_at = wreg ? e.cycles : 0;
      e.pcw     = 1;
    end
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (instr !== 32'h0000_0013 || retire_count !== 32'd0 || fault !== 1'b0 ||
        fault_code !== 2'd0 || dbg_state !== FETCH) begin
      n_bad++;
      $display("FAIL reset_state: instr=%h retire=%0d fault=%b code=%0d state=%0d want 00000013/0/0/0/FETCH",
               instr, retire_count, fault, fault_code, dbg_state);
    end
    n_cmp++;
    if ({mem_bus.instr_mem_req, mem_bus.data_mem_read_req, mem_bus.data_mem_write_req,
         reg_write_en, pc_write_en} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outputs: req/rd/wr/regw/pcw=%b want 10000",
               {mem_bus.instr_mem_req, mem_bus.data_mem_read_req, mem_bus.data_mem_write_req,
                reg_write_en, pc_write_en});
    end
  endtask

  task automatic test_addi();
    obs_t o;
    do_reset();
    set_decoder(32'h0050_0093);
    run_instr(32'h0050_0093, 0, 0, o);
    n_cmp++;
    if (o.cycles !== 4 || o.regw !== 1 || o.regw_at !== 4 || o.pcw !== 1) begin
      n_bad++;
      $display("FAIL addi_timing: cycles=%0d regw=%0d@%0d pcw=%0d want 4, 1@4, 1",
               o.cycles, o.regw, o.regw_at, o.pcw);
    end
    n_cmp++;
    if (retire_count !== 32'd1 || instr !== 32'h0050_0093) begin
      n_bad++;
      $display("FAIL addi_retire: retire=%0d instr=%h want 1, 00500093", retire_count, instr);
    end
    model_retire = 32'd1;
  endtask

  task automatic test_lw_delayed();
    obs_t o;
    set_decoder(32'h0000_a103);
    run_instr(32'h0000_a103, 0, 3, o);
    n_cmp++;
    if (o.cycles !== 8 || o.rd_cyc !== 4 || o.wr_cyc !== 0 || o.regw !== 1 || o.regw_at !== 8) begin
      n_bad++;
      $display("FAIL lw_delayed: cycles=%0d rd=%0d wr=%0d regw=%0d@%0d want 8,4,0,1@8",
               o.cycles, o.rd_cyc, o.wr_cyc, o.regw, o.regw_at);
    end
    model_retire++;
    n_cmp++;
    if (retire_count !== model_retire) begin
      n_bad++;
      $display("FAIL lw_retire: got %0d want %0d", retire_count, model_retire);
    end
  endtask

  task automatic test_sw();
    obs_t o;
    set_decoder(32'h0020_a023);
    run_instr(32'h0020_a023, 0, 1, o);
    n_cmp++;
    if (o.wr_cyc !== 2 || o.rd_cyc !== 0 || o.regw !== 0 || o.pcw !== 1 || o.cycles !== 6) begin
      n_bad++;
      $display("FAIL sw: wr=%0d rd=%0d regw=%0d pcw=%0d cycles=%0d want 2,0,0,1,6",
               o.wr_cyc, o.rd_cyc, o.regw, o.pcw, o.cycles);
    end
    model_retire++;
  endtask

  task automatic test_fence();
    obs_t o;
    set_decoder(32'h0ff0_000f);
    run_instr(32'h0ff0_000f, 0, 0, o);
    n_cmp++;
    if (o.cycles !== 4 || o.regw !== 0 || o.pcw !== 1 || o.rd_cyc !== 0 || o.wr_cyc !== 0) begin
      n_bad++;
      $display("FAIL fence: cycles=%0d regw=%0d pcw=%0d rd=%0d wr=%0d want 4,0,1,0,0",
               o.cycles, o.regw, o.pcw, o.rd_cyc, o.wr_cyc);
    end
    model_retire++;
    n_cmp++;
    if (retire_count !== model_retire) begin
      n_bad++;
      $display("FAIL fence_retire: got %0d want %0d", retire_count, model_retire);
    end
  endtask

  task automatic test_illegal_zero();
    obs_t o;
    bit   bad;
    set_decoder(32'h0000_0000);
    run_instr(32'h0000_0000, 1, 0, o);
    n_cmp++;
    if (o.faulted !== 1'b1 || o.code !== 2'd1 || o.cycles !== 4 || o.pcw !== 0) begin
      n_bad++;
      $display("FAIL illegal_fault: faulted=%b code=%0d cycles=%0d pcw=%0d want 1,1,4,0",
               o.faulted, o.code, o.cycles, o.pcw);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_bus.instr_mem_ready = 1'($urandom_range(0, 1));
      mem_bus.data_mem_ready  = 1'($urandom_range(0, 1));
      if (mem_bus.instr_mem_req || mem_bus.data_mem_read_req || mem_bus.data_mem_write_req ||
          reg_write_en || pc_write_en || fault !== 1'b1 || fault_code !== 2'd1 ||
          instr !== 32'd0 || retire_count !== model_retire) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL fault_hold: outputs moved in FAULT, got code=%0d retire=%0d want 1, %0d",
               fault_code, retire_count, model_retire);
    end
  endtask

  task automatic test_fetch_timeout();
    obs_t o;
    do_reset();
    set_decoder(32'h0050_0093);
    run_instr(32'h0050_0093, T, 0, o);
    n_cmp++;
    if (o.faulted !== 1'b1 || o.code !== 2'd2 || o.cycles !== T + 1) begin
      n_bad++;
      $display("FAIL fetch_timeout: faulted=%b code=%0d cycles=%0d want 1,2,%0d",
               o.faulted, o.code, o.cycles, T + 1);
    end
    do_reset();
    run_instr(32'h0050_0093, T - 1, 0, o);
    n_cmp++;
    if (o.faulted !== 1'b0 || o.cycles !== T + 3 || o.pcw !== 1 || retire_count !== 32'd1) begin
      n_bad++;
      $display("FAIL fetch_ready_at_limit: faulted=%b cycles=%0d pcw=%0d retire=%0d want 0,%0d,1,1",
               o.faulted, o.cycles, o.pcw, retire_count, T + 3);
    end
    model_retire = 32'd1;
  endtask

  task automatic test_data_timeout();
    obs_t o;
    set_decoder(32'h0000_a103);
    run_instr(32'h0000_a103, 0, T, o);
    n_cmp++;
    if (o.faulted !== 1'b1 || o.code !== 2'd3 || o.rd_cyc !== T || o.regw !== 0) begin
      n_bad++;
      $display("FAIL data_timeout: faulted=%b code=%0d rd=%0d regw=%0d want 1,3,%0d,0",
               o.faulted, o.code, o.rd_cyc, o.regw, T);
    end
    n_cmp++;
    if (retire_count !== model_retire) begin
      n_bad++;
      $display("FAIL data_timeout_retire: got %0d want %0d", retire_count, model_retire);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    int   seen;
    bit   strobe;
    do_reset();
    set_decoder(32'h0050_0093);
    run_instr(32'h0050_0093, 0, 0, o);
    set_decoder(32'h0000_a103);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      mem_bus.instr_mem_ready = mem_bus.instr_mem_req;
      mem_bus.instr_mem_data  = 32'h0000_a103;
      mem_bus.data_mem_ready  = 1'b0;
      if (mem_bus.data_mem_read_req) seen++;
      if (seen < 2) @(negedge clk);
    end
    reset = 1'b1;
    mem_bus.instr_mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seen !== 2 || dbg_state !== FETCH || retire_count !== 32'd0 ||
        mem_bus.data_mem_read_req !== 1'b0 || reg_write_en !== 1'b0 ||
        mem_bus.instr_mem_req !== 1'b1 || instr !== 32'h0000_0013) begin
      n_bad++;
      $display("FAIL reset_mid_mem: seen=%0d state=%0d retire=%0d rdreq=%b regw=%b ireq=%b instr=%h want 2,FETCH,0,0,0,1,00000013",
               seen, dbg_state, retire_count, mem_bus.data_mem_read_req, reg_write_en,
               mem_bus.instr_mem_req, instr);
    end
    reset = 1'b0;
    strobe = 0;
    for (int i = 0; i < 3; i++) begin
      if (reg_write_en || pc_write_en) strobe = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (strobe) begin
      n_bad++;
      $display("FAIL reset_mid_mem_strobe: write strobe after reset, got 1 want 0");
    end
    do_reset();
  endtask

  task automatic test_random();
    obs_t        o;
    obs_t        e;
    logic [31:0] w;
    int          fw;
    int          mw;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      w = $urandom();
      if ($urandom_range(0, 7) != 0) begin
        w[6:2] = legal_ops[$urandom_range(0, 9)];
        w[1:0] = 2'b11;
      end
      set_decoder(w);
      if ($urandom_range(0, 15) == 0) begin
        should_read_mem = 1'b1; should_write_mem = 1'b1;
      end
      fw = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, T - 1);
      mw = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, T - 1);
      e = model_instr(w, fw, mw, should_read_mem, should_write_mem, should_write_reg);
      run_instr(w, fw, mw, o);
      n_cmp++;
      if (o.cycles !== e.cycles || o.faulted !== e.faulted || o.code !== e.code ||
          o.rd_cyc !== e.rd_cyc || o.wr_cyc !== e.wr_cyc || o.regw !== e.regw ||
          o.regw_at !== e.regw_at || o.pcw !== e.pcw) begin
        n_bad++;
        $display("FAIL rand_instr %0d w=%h fw=%0d mw=%0d: got cyc=%0d flt=%b code=%0d rd=%0d wr=%0d regw=%0d@%0d pcw=%0d want cyc=%0d flt=%b code=%0d rd=%0d wr=%0d regw=%0d@%0d pcw=%0d",
                 n, w, fw, mw, o.cycles, o.faulted, o.code, o.rd_cyc, o.wr_cyc, o.regw,
                 o.regw_at, o.pcw, e.cycles, e.faulted, e.code, e.rd_cyc, e.wr_cyc,
                 e.regw, e.regw_at, e.pcw);
      end
      if (!e.faulted) model_retire++;
      n_cmp++;
      if (retire_count !== model_retire || (!e.faulted && instr !== w)) begin
        n_bad++;
        $display("FAIL rand_retire %0d: retire=%0d instr=%h want %0d, %h",
                 n, retire_count, instr, model_retire, w);
      end
      if (e.faulted) do_reset();
    end
  endtask

  initial begin
    mem_bus.instr_mem_ready = 1'b0;
    mem_bus.instr_mem_data  = 32'd0;
    mem_bus.data_mem_ready  = 1'b0;
    test_reset();
    test_addi();
    test_lw_delayed();
    test_sw();
    test_fence();
    test_illegal_zero();
    test_fetch_timeout();
    test_data_timeout();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the single-issue RV32I core. Steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction and data memory ports. Turns the instruction-control decoder's level signals (should_read_mem, should_write_mem, should_write_reg) into per-cycle enables for the instruction register, register file, data memory and PC. Sits between the top-level core wrapper and the datapath.

## Interface

- MEM_TIMEOUT, 16: max cycles to wait for any memory ready before faulting; legal range 1..255.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr_mem_req  out  1  instruction fetch request, held until ready
- instr_mem_ready  in  1  fetch data valid this cycle
- instr_mem_data  in  32  fetched word
- instr  out  32  instruction register, fed to the control decoder and datapath
- should_read_mem  in  1  from decoder, valid from DECODE onward
- should_write_mem  in  1  from decoder
- should_write_reg  in  1  from decoder
- data_mem_read_req  out  1  load request, held until ready
- data_mem_write_req  out  1  store request, held until ready
- data_mem_ready  in  1  load data valid / store accepted
- reg_write_en  out  1  one-cycle register-file write strobe
- pc_write_en  out  1  one-cycle PC update strobe
- retire_count  out  32  instructions retired since reset
- fault  out  1  sticky; core halted
- fault_code  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout

## Operation

- States: FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset state is FETCH.
- FETCH: instr_mem_req=1. When instr_mem_ready=1, instr <= instr_mem_data and go to DECODE.
- DECODE: one cycle. Illegal if instr[1:0]!=2'b11, or instr[6:2] is not one of 00,03,04,05,08,0c,0d,18,19,1b, or should_read_mem && should_write_mem. Illegal goes to FAULT with code 1; otherwise EXEC.
- EXEC: one cycle, ALU settles. Go to MEM if should_read_mem or should_write_mem, else WB.
- MEM: data_mem_read_req = should_read_mem, data_mem_write_req = should_write_mem, both held until data_mem_ready=1, then WB.
- WB: reg_write_en = should_write_reg; pc_write_en=1; retire_count += 1 (wraps 0xFFFFFFFF to 0); then FETCH.
- Fence (03) is a nop: DECODE, EXEC, WB with reg_write_en=0 and pc_write_en=1.
- Wait counter: cleared on entry to FETCH and to MEM, increments each cycle ready is low. If it reaches MEM_TIMEOUT with ready still low, go to FAULT with code 2 (FETCH) or 3 (MEM). Ready on the same cycle the count reaches the limit wins; no fault.
- FAULT: all request and strobe outputs 0. instr, retire_count and fault_code hold. Left only by reset.
- Outputs are Moore outputs decoded from state, except reg_write_en and the data request lines, which also gate on the decoder inputs.

## Timing

- Reset values: state FETCH, instr 32'h00000013 (nop), retire_count 0, fault 0, fault_code 0, wait counter 0. instr_mem_req=1 in the first cycle after reset deasserts.
- Reset is synchronous and overrides everything, including mid-MEM. Outstanding requests drop the next cycle; no write strobe is issued.
- Latency with zero-wait memory: ALU, branch, jump, LUI, AUIPC and fence take 4 cycles (F, D, E, W). Load and store take 5 (F, D, E, M, W). Each wait cycle adds 1.
- Ready is ignored outside its wait state.
- Requests stay high through the ready cycle and drop the cycle after.
- reg_write_en and pc_write_en are high for exactly one cycle per retired instruction.

## Structure

- Shared package core_pkg holds:
  - the state enum;
  - fault code constants;
  - RV32I opcode[6:2] constants, shared with the instruction-control decoder so the legality list cannot diverge.
- One sub-module, mem_wait_timer: clear, tick, limit and expired ports; 8-bit counter. It is instantiated once, because FETCH and MEM never overlap.

## Test plan

- ADDI x1,x0,5 (0x00500093) with zero-wait fetch:
  - 4 cycles;
  - reg_write_en pulses in cycle 4;
  - retire_count 0 to 1.
- LW (0x0000a103) with data_mem_ready delayed 3 cycles:
  - data_mem_read_req high 4 cycles;
  - WB follows, reg_write_en=1;
  - total 8 cycles.
- SW (0x0020a023):
  - data_mem_write_req asserted;
  - reg_write_en stays 0 and pc_write_en pulses.
- Fetch word 0x00000000, whose low bits are not 11:
  - FAULT with fault_code=1;
  - all strobes 0 for 20 following cycles.
- MEM_TIMEOUT=4 with instr_mem_ready held low:
  - fault_code=2 after 4 cycles;
  - ready on exactly cycle 4 proceeds to DECODE instead.
- Reset asserted mid-MEM of a load:
  - next cycle state FETCH, retire_count 0, no reg_write_en pulse.
